// File: rtl/mem_dma_master.sv
// mem_dma_master: bus-initiator copy engine, one read then one write per word.
// Latency: >= 4 cycles per word plus responder latency; one-cycle done_irq at the end.
// Backpressure: waits for bus_grant between words and for responder busy to fall;
//   optional fill mode (write cfg_pattern, no reads) is built in when DMA_FILL_EN is defined.
module mem_dma_master #(
  parameter int ADDR_W = 27,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_fill,
  input  logic [31:0]       cfg_pattern,
  input  logic              go,
  output logic              dma_busy,
  output logic              done_irq,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       data,
  output logic              we,
  output logic              start,
  input  logic              busy,
  input  logic [31:0]       q
);

  typedef enum logic [2:0] {
    IDLE, REQ, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, FIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [LEN_W-1:0]  count;
  logic [31:0]       word_buf;
  logic              fill_mode;

  // Fill request as seen by the engine; tied off when fill support is not built.
  logic              fill_go;
  logic [31:0]       fill_word;
`ifdef DMA_FILL_EN
  assign fill_go   = cfg_fill;
  assign fill_word = cfg_pattern;
`else
  logic unused_fill;
  assign fill_go     = 1'b0;
  assign fill_word   = '0;
  assign unused_fill = ^{cfg_fill, cfg_pattern};
`endif

  // Transfer sequencer; every output is a register updated on the transition
  // that enters the state it belongs to. Each ISSUE state first spends one
  // cycle with start low, which guarantees the gap between transactions.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      count     <= '0;
      word_buf  <= '0;
      fill_mode <= 1'b0;
      dma_busy  <= 1'b0;
      done_irq  <= 1'b0;
      bus_req   <= 1'b0;
      address   <= '0;
      data      <= '0;
      we        <= 1'b0;
      start     <= 1'b0;
    end else begin
      done_irq <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            dma_busy <= 1'b1;
            if (cfg_len != '0) begin
              src_ptr   <= cfg_src;
              dst_ptr   <= cfg_dst;
              count     <= cfg_len;
              fill_mode <= fill_go;
              if (fill_go) word_buf <= fill_word;
              bus_req   <= 1'b1;
              state     <= REQ;
            end else begin
              // Empty transfer: complete immediately without touching the bus.
              done_irq <= 1'b1;
              state    <= FIN;
            end
          end
        end
        REQ: begin
          if (bus_grant) state <= fill_mode ? WR_ISSUE : RD_ISSUE;
        end
        RD_ISSUE: begin
          if (!start) begin
            address <= src_ptr;
            we      <= 1'b0;
            start   <= 1'b1;
          end else if (busy) begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (!busy) begin
            word_buf <= q;
            start    <= 1'b0;
            state    <= WR_ISSUE;
          end
        end
        WR_ISSUE: begin
          if (!start) begin
            address <= dst_ptr;
            data    <= word_buf;
            we      <= 1'b1;
            start   <= 1'b1;
          end else if (busy) begin
            state <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (!busy) begin
            start   <= 1'b0;
            we      <= 1'b0;
            dst_ptr <= dst_ptr + ADDR_W'(1);
            if (!fill_mode) src_ptr <= src_ptr + ADDR_W'(1);
            count   <= count - LEN_W'(1);
            // Grant is only re-examined here, between words.
            if (count == LEN_W'(1)) begin
              done_irq <= 1'b1;
              dma_busy <= 1'b0;
              bus_req  <= 1'b0;
              state    <= FIN;
            end else if (bus_grant) begin
              state <= fill_mode ? WR_ISSUE : RD_ISSUE;
            end else begin
              state <= REQ;
            end
          end
        end
        FIN: begin
          dma_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_dma_master.md
Name: mem_dma_master

Overview:
- Bus initiator (DMA copy engine) for the memory-mapped start/busy/q interface served by the memory unit.
- Copies a block of 32-bit words from a source address to a destination address.
- Each word is one read transaction followed by one write transaction.
- Arbitrates with the CPU for the bus using a req/grant pair, and raises a one-cycle completion interrupt.

Parameters:
- ADDR_W, 27, width of the word address on the memory bus.
- LEN_W, 16, width of the transfer word count.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- cfg_src  input  ADDR_W  source start word address; sampled on go.
- cfg_dst  input  ADDR_W  destination start word address; sampled on go.
- cfg_len  input  LEN_W  number of words to copy; sampled on go.
- cfg_fill  input  1  fill mode select; only used with DMA_FILL_EN.
- cfg_pattern  input  32  fill word; only used with DMA_FILL_EN.
- go  input  1  one-cycle start strobe.
- dma_busy  output  1  high from accepted go until done.
- done_irq  output  1  one-cycle pulse when the transfer completes.
- bus_req  output  1  bus request to the arbiter.
- bus_grant  input  1  arbiter grant.
- address  output  ADDR_W  memory bus address.
- data  output  32  memory bus write data.
- we  output  1  memory bus write enable.
- start  output  1  memory bus start; held until the responder drops busy.
- busy  input  1  responder busy.
- q  input  32  responder read data; valid when busy falls.

Behaviour:
- Reset values: all outputs 0, including address, data, we and start. State = IDLE, internal pointers/count/buffer = 0.
- Reset mid-transfer: immediate return to IDLE, start/bus_req dropped, no done_irq.
- States: IDLE, REQ, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, FIN.
- IDLE:
  - go=1 and cfg_len!=0: latch src_ptr, dst_ptr and remaining count; dma_busy=1; go to REQ.
  - go=1 and cfg_len==0: go to FIN with no bus activity. dma_busy pulses high for that one cycle.
  - go while dma_busy=1 is ignored.
- REQ: bus_req=1. Stay until bus_grant=1, then go to RD_ISSUE.
- RD_ISSUE: address=src_ptr, we=0, start=1. Go to RD_WAIT once busy is sampled 1.
- RD_WAIT:
  - start stays 1 until busy is sampled 0.
  - On busy=0: capture q into word buffer, start=0 in the same cycle, go to WR_ISSUE.
- WR_ISSUE: address=dst_ptr, data=buffer, we=1, start=1. Go to WR_WAIT once busy is sampled 1.
- WR_WAIT:
  - On busy=0: start=0 and we=0.
  - Increment src_ptr and dst_ptr by 1, modulo 2^ADDR_W (wrap from all-ones to 0 is legal).
  - Decrement the count.
  - If count reaches 0, go to FIN.
  - Else if bus_grant=1, go to RD_ISSUE.
  - Else go to REQ.
- Grant loss: grant is only checked between words. A transaction in flight (start asserted) always completes, even if bus_grant drops.
- bus_req=1 in all states except IDLE and FIN.
- FIN: done_irq=1 for exactly one cycle, dma_busy=0, bus_req=0, return to IDLE.
- Handshake rules:
  - start never rises in the same cycle it fell. There is at least one cycle with start=0 between transactions.
  - address, data and we are stable for the whole interval start=1.
  - Busy is observed on posedge; the responder's negedge updates are therefore seen one half-cycle later, which is legal.
- Minimum cost per word: 4 cycles plus responder latency. No timeout; a responder that never drops busy stalls the engine until reset.

Optional Feature:
- Macro DMA_FILL_EN.
- Defined:
  - If cfg_fill=1 at go, the buffer loads cfg_pattern.
  - RD_ISSUE/RD_WAIT are skipped: each word goes WR_ISSUE→WR_WAIT, and only dst_ptr increments.
  - With cfg_fill=0, behaviour is unchanged.
- Not defined: cfg_fill and cfg_pattern are ignored (unconnected); every transfer is a copy.

Test Plan:
- Basic copy:
  - Stimulus: src=0x000010, dst=0xC00000, len=3 with a 2-cycle-latency responder model.
  - Required response: reads 0x10,0x11,0x12; writes 0xC00000..0xC00002 with matching q data; exactly one done_irq; start gaps ≥1 cycle.
- Zero length:
  - Stimulus: len=0, go.
  - Required response: done_irq one cycle later; bus_req and start never asserted.
- Grant withdrawn mid-read:
  - Stimulus: len=2; drop bus_grant during the first RD_WAIT.
  - Required response: first read and write complete; engine sits in REQ with start=0; resumes word 2 when grant returns; done_irq once.
- Address wrap:
  - Stimulus: src=0x7FFFFFF, dst=0x0000100, len=2.
  - Required response: second read at address 0x0000000; second write at 0x0000101.
- Reset mid-write:
  - Stimulus: assert reset while start=1 in WR_WAIT.
  - Required response: the next cycle shows start=0, we=0, bus_req=0, dma_busy=0, no done_irq; a new go then works normally.
- DMA_FILL_EN:
  - Stimulus: fill=1, pattern=0xDEADBEEF, dst=0x200, len=4.
  - Required response: four writes of 0xDEADBEEF to 0x200..0x203; zero read transactions.
